// File: rtl/rand_pkg.sv
// Shared constants, FSM state type and the rejection-sampling mask helper.
package rand_pkg;

    localparam int RND_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Smallest 2^k-1 that covers range-1; smearing the top set bit downwards gives it directly.
    function automatic logic [31:0] mask_of(input logic [31:0] range);
        logic [31:0] m;
        m = range - 32'd1;
        for (int s = 1; s < 32; s = s * 2) begin
            m = m | (m >> s);
        end
        return m;
    endfunction

endpackage

// File: rtl/rand_fifo.sv
// Small prefetch FIFO with a synchronous flush; head is the combinational read of the oldest entry.
module rand_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               data_i,
    output logic [W-1:0]               head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [AW-1:0]           wr_q, rd_q;
    logic [CW-1:0]           cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_i) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/rand_range_sampler.sv
// Mask-and-reject sampler: turns a free-running LFSR word into uniform values in [0, range)
// and prefetches accepted values into a FIFO drained over valid/ready.
module rand_range_sampler
    import rand_pkg::*;
#(
    parameter int RND_W  = rand_pkg::RND_W,
    parameter int DEPTH  = 4,
    parameter int STRIDE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RND_W-1:0] rnd_in,
    input  logic [RND_W-1:0] range_in,
    input  logic             range_load,
    output logic [RND_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             range_invalid,
    output logic [15:0]      reject_count
);

    localparam int          CW          = $clog2(DEPTH) + 1;
    localparam logic [3:0]  STRIDE_LAST = 4'(STRIDE - 1);

    state_e           state_q, state_d;
    logic [RND_W-1:0] range_q, range_d;
    logic [RND_W-1:0] mask_q, mask_d;
    logic             inv_q, inv_d;
    logic [3:0]       stride_q, stride_d;
    logic [15:0]      rej_q, rej_d;

    logic [RND_W-1:0] cand;
    logic             accept, sample, push, pop, full;
    logic [RND_W-1:0] head;
    logic [CW-1:0]    count;

    assign full = (count == CW'(DEPTH));

    always_comb begin
        state_d  = state_q;
        range_d  = range_q;
        mask_d   = mask_q;
        inv_d    = inv_q;
        stride_d = (stride_q == STRIDE_LAST) ? 4'd0 : stride_q + 4'd1;
        rej_d    = rej_q;
        push     = 1'b0;
        pop      = 1'b0;
        cand     = rnd_in & mask_q;
        accept   = (cand < range_q);
        sample   = (state_q == RUN) && (stride_q == 4'd0);

        // A load wins over everything in its cycle: in-flight push/pop are discarded.
        if (range_load) begin
            range_d  = range_in;
            mask_d   = RND_W'(mask_of(32'(range_in)));
            inv_d    = (range_in == '0);
            state_d  = (range_in != '0) ? RUN : IDLE;
            stride_d = 4'd0;
            rej_d    = 16'd0;
        end else begin
            pop = (count != '0) && out_ready;
            if (sample) begin
                if (accept) begin
                    push = !full || pop;
                end else if (rej_q != 16'hFFFF) begin
                    rej_d = rej_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            range_q  <= '0;
            mask_q   <= '0;
            inv_q    <= 1'b1;
            stride_q <= 4'd0;
            rej_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            range_q  <= range_d;
            mask_q   <= mask_d;
            inv_q    <= inv_d;
            stride_q <= stride_d;
            rej_q    <= rej_d;
        end
    end

    rand_fifo #(
        .W     (RND_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (range_load),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (cand),
        .head_o  (head),
        .count_o (count)
    );

    assign out_data      = head;
    assign out_valid     = (count != '0);
    assign range_invalid = inv_q;
    assign reject_count  = rej_q;

endmodule

// File: tb/tb_rand_range_sampler.sv
// Bench for rand_range_sampler: two instances (STRIDE 1 and 4) checked every cycle against a
// queue-based reference model, plus directed checks on latency, rejection, flush and stride.
module tb_rand_range_sampler;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] rnd;

    logic [15:0] rng_a, data_a, rej_a;
    logic        ld_a, rdy_a, vld_a, inv_a;
    logic [15:0] rng_b, data_b, rej_b;
    logic        ld_b, rdy_b, vld_b, inv_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rand_range_sampler #(.RND_W(16), .DEPTH(DEPTH), .STRIDE(1)) u_dut_a (
        .clk(clk), .reset(reset), .rnd_in(rnd), .range_in(rng_a), .range_load(ld_a),
        .out_data(data_a), .out_valid(vld_a), .out_ready(rdy_a),
        .range_invalid(inv_a), .reject_count(rej_a)
    );

    rand_range_sampler #(.RND_W(16), .DEPTH(DEPTH), .STRIDE(4)) u_dut_b (
        .clk(clk), .reset(reset), .rnd_in(rnd), .range_in(rng_b), .range_load(ld_b),
        .out_data(data_b), .out_valid(vld_b), .out_ready(rdy_b),
        .range_invalid(inv_b), .reject_count(rej_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: latched range, queue of buffered values, reject counter, stride phase.
    int unsigned m_rng [2];
    int unsigned m_rej [2];
    int unsigned m_ph  [2];
    int unsigned m_q   [2][$];

    function automatic int unsigned mask_ref(input int unsigned r);
        int unsigned m = 0;
        while (m + 1 < r) m = m * 2 + 1;
        return m;
    endfunction

    task automatic model_step(input int d, input bit ld, input int unsigned rin,
                              input bit rdy, input int stride);
        int unsigned c;
        if (reset) begin
            m_rng[d] = 0; m_rej[d] = 0; m_ph[d] = 0; m_q[d].delete();
        end else if (ld) begin
            m_rng[d] = rin; m_rej[d] = 0; m_ph[d] = 0; m_q[d].delete();
        end else begin
            if (m_q[d].size() > 0 && rdy) void'(m_q[d].pop_front());
            if (m_rng[d] != 0 && m_ph[d] == 0) begin
                c = rnd & mask_ref(m_rng[d]);
                if (c < m_rng[d]) begin
                    if (m_q[d].size() < DEPTH) m_q[d].push_back(c);
                end else if (m_rej[d] < 65535) begin
                    m_rej[d]++;
                end
            end
            m_ph[d] = (m_ph[d] + 1) % stride;
        end
    endtask

    task automatic cmp_model(input int d, input logic v, input logic [15:0] dat,
                             input logic inv, input logic [15:0] rej);
        chk($sformatf("m%0d_valid", d), 32'(v), 32'(m_q[d].size() > 0));
        if (m_q[d].size() > 0) chk($sformatf("m%0d_data", d), 32'(dat), m_q[d][0]);
        chk($sformatf("m%0d_inv", d), 32'(inv), 32'(m_rng[d] == 0));
        chk($sformatf("m%0d_rej", d), 32'(rej), m_rej[d]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, ld_a, rng_a, rdy_a, 1);
        model_step(1, ld_b, rng_b, rdy_b, 4);
        @(negedge clk);
        cmp_model(0, vld_a, data_a, inv_a, rej_a);
        cmp_model(1, vld_b, data_b, inv_b, rej_b);
    endtask

    function automatic logic [15:0] rand_range();
        case ($urandom % 4)
            0:       return 16'($urandom % 20);
            1:       return 16'($urandom);
            2:       return 16'h8000;
            default: return 16'(1 << ($urandom % 16));
        endcase
    endfunction

    initial begin
        reset = 1'b1; rnd = '0;
        rng_a = '0; ld_a = 1'b0; rdy_a = 1'b0;
        rng_b = '0; ld_b = 1'b0; rdy_b = 1'b0;
        @(negedge clk);
        tick(); tick();
        chk("rst_valid", 32'(vld_a), 32'd0);
        chk("rst_data",  32'(data_a), 32'd0);
        chk("rst_inv",   32'(inv_a), 32'd1);
        chk("rst_rej",   32'(rej_a), 32'd0);
        reset = 1'b0;

        // range 10, constant 7, no consumer: valid two cycles after load, then fills and holds
        rnd = 16'h0007; rng_a = 16'd10; ld_a = 1'b1;
        tick(); ld_a = 1'b0;
        chk("lat_n1_valid", 32'(vld_a), 32'd0);
        tick();
        chk("lat_n2_valid", 32'(vld_a), 32'd1);
        chk("lat_n2_data",  32'(data_a), 32'd7);
        repeat (6) tick();
        chk("full_data", 32'(data_a), 32'd7);
        chk("full_rej",  32'(rej_a), 32'd0);

        // candidate 12 always rejected
        rnd = 16'h000C; ld_a = 1'b1;
        tick(); ld_a = 1'b0;
        repeat (6) tick();
        chk("rej_count", 32'(rej_a), 32'd6);
        chk("rej_valid", 32'(vld_a), 32'd0);

        // range 1: only value 0, continuous flow with consumer always ready
        rng_a = 16'd1; rdy_a = 1'b1; ld_a = 1'b1;
        tick(); ld_a = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            rnd = 16'($urandom);
            chk("r1_valid", 32'(vld_a), 32'd1);
            chk("r1_data",  32'(data_a), 32'd0);
            tick();
        end

        // fill, then reload 0x8000 while consumer ready: flushed, then 0x7FFF mask
        rdy_a = 1'b0; rnd = 16'h0007; rng_a = 16'd10; ld_a = 1'b1;
        tick(); ld_a = 1'b0;
        repeat (6) tick();
        rng_a = 16'h8000; rnd = 16'hFFFF; rdy_a = 1'b1; ld_a = 1'b1;
        tick(); ld_a = 1'b0;
        chk("flush_valid", 32'(vld_a), 32'd0);
        tick();
        chk("big_valid", 32'(vld_a), 32'd1);
        chk("big_data",  32'(data_a), 32'h7FFF);
        rdy_a = 1'b0;

        // stride 4, range 256, incrementing words from the load cycle
        rng_b = 16'd256; rnd = 16'd0; ld_b = 1'b1;
        tick(); ld_b = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            rnd = 16'(i);
            tick();
        end
        rdy_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("stride_valid", 32'(vld_b), 32'd1);
            chk("stride_data",  32'(data_b), 32'(1 + 4 * k));
            rnd = rnd + 16'd1;
            tick();
        end
        rdy_b = 1'b0; rng_b = 16'd0; ld_b = 1'b1;
        tick(); ld_b = 1'b0;
        chk("zero_inv",   32'(inv_b), 32'd1);
        chk("zero_valid", 32'(vld_b), 32'd0);
        repeat (8) begin
            rnd = 16'($urandom);
            tick();
        end
        chk("zero_hold_valid", 32'(vld_b), 32'd0);

        // randomized traffic, occasional reloads and resets
        for (int i = 0; i < 600; i++) begin
            rnd   = 16'($urandom);
            rdy_a = 1'($urandom % 2);
            rdy_b = 1'($urandom % 2);
            ld_a  = ($urandom % 25 == 0);
            ld_b  = ($urandom % 25 == 0);
            if (ld_a) rng_a = rand_range();
            if (ld_b) rng_b = rand_range();
            reset = ($urandom % 150 == 0);
            tick();
        end
        reset = 1'b0; ld_a = 1'b0; ld_b = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
